// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_W_DEF      = 32;
    localparam int unsigned BE_W_DEF       = MEM_W_DEF / 8;
    localparam logic [31:0] SRAM_LIMIT_DEF = 32'h0000_2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_IFETCH = 1'b0,
        PORT_DATA   = 1'b1
    } port_id_e;

    typedef struct packed {
        logic [31:0]          addr;
        logic                 we;
        logic [BE_W_DEF-1:0]  be;
        logic [MEM_W_DEF-1:0] wdata;
        port_id_e             port;
    } mem_req_t;

    // Only writes are fenced off above the SRAM window; reads go downstream.
    function automatic logic is_rejected(input logic we, input logic [31:0] addr,
                                         input logic [31:0] limit);
        return we && (addr >= limit);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grant is combinational, rr_last updates on grant.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_ifetch,
    input  logic       req_data,
    input  logic       en,
    input  logic       update,
    output logic [1:0] gnt
);

    port_id_e rr_last;

    // gnt[0] = ifetch, gnt[1] = data
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req_ifetch && req_data) begin
                gnt = (rr_last == PORT_DATA) ? 2'b01 : 2'b10;
            end else if (req_ifetch) begin
                gnt = 2'b01;
            end else if (req_data) begin
                gnt = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last <= PORT_DATA;
        end else if (update && (gnt != 2'b00)) begin
            rr_last <= gnt[1] ? PORT_DATA : PORT_IFETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the ifetch and data ports onto the single-outstanding storage_controller interface.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no transaction; arbitrate and grant combinationally
//   ST_ISSUE | one-cycle memory_access pulse (suppressed for rejected writes)
//   ST_WAIT  | wait for out_valid (read) or WR_LAT cycles (write), with timeout
//   ST_RESP  | one-cycle rvalid to the owning port with registered rdata/err
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_W      = MEM_W_DEF,
    parameter logic [31:0] SRAM_LIMIT = SRAM_LIMIT_DEF,
    parameter int unsigned WR_LAT     = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_mode,
    input  logic               ifetch_req,
    input  logic [31:0]        ifetch_addr,
    output logic               ifetch_gnt,
    output logic               ifetch_rvalid,
    output logic [MEM_W-1:0]   ifetch_rdata,
    output logic               ifetch_err,
    input  logic               data_req,
    input  logic               data_we,
    input  logic [MEM_W/8-1:0] data_be,
    input  logic [31:0]        data_addr,
    input  logic [MEM_W-1:0]   data_wdata,
    output logic               data_gnt,
    output logic               data_rvalid,
    output logic [MEM_W-1:0]   data_rdata,
    output logic               data_err,
    output logic               memory_access,
    output logic               memory_is_writing,
    output logic [31:0]        addr,
    output logic [MEM_W-1:0]   d_in,
    output logic [MEM_W/8-1:0] mem_be,
    input  logic [MEM_W-1:0]   d_out,
    input  logic               out_valid
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_WR = CNT_W'(WR_LAT);

    arb_state_e       state;
    arb_state_e       state_nxt;
    mem_req_t         req_q;
    mem_req_t         req_new;
    logic             rej_q;
    logic             run_q;
    logic [CNT_W-1:0] cnt;
    logic [MEM_W-1:0] rdata_q;
    logic             err_q;
    logic             arb_en;
    logic [1:0]       arb_gnt;
    logic             grant_any;
    logic             resp_ifetch;
    logic             resp_data;

    // run_q drops asynchronously with reset so no grant can leak out while rst is low.
    assign arb_en    = run_q && (state == ST_IDLE) && !prog_mode;
    assign grant_any = |arb_gnt;

    rr_arbiter2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .req_ifetch (ifetch_req),
        .req_data   (data_req),
        .en         (arb_en),
        .update     (arb_en),
        .gnt        (arb_gnt)
    );

    assign ifetch_gnt = arb_gnt[0];
    assign data_gnt   = arb_gnt[1];

    always_comb begin
        req_new = '0;
        if (arb_gnt[1]) begin
            req_new.addr  = data_addr;
            req_new.we    = data_we;
            req_new.be    = data_be;
            req_new.wdata = data_wdata;
            req_new.port  = PORT_DATA;
        end else begin
            req_new.addr  = ifetch_addr;
            req_new.we    = 1'b0;
            req_new.be    = '1;
            req_new.wdata = '0;
            req_new.port  = PORT_IFETCH;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = rej_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (!req_q.we) begin
                    if (out_valid || (cnt == CNT_TO)) begin
                        state_nxt = ST_RESP;
                    end
                end else if (cnt == CNT_WR) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= '0;
            rej_q   <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant_any) begin
                req_q <= req_new;
                rej_q <= is_rejected(req_new.we, req_new.addr, SRAM_LIMIT);
            end
            if (state == ST_ISSUE) begin
                cnt <= '0;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Response payload is resolved on the cycle that enters RESP.
            if (state_nxt == ST_RESP) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
                if (state == ST_ISSUE) begin
                    err_q <= 1'b1;
                end else if (!req_q.we) begin
                    if (out_valid) begin
                        rdata_q <= d_out;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign memory_access     = (state == ST_ISSUE) && !rej_q;
    assign memory_is_writing = req_q.we && !rej_q;
    assign addr              = req_q.addr;
    assign d_in              = req_q.wdata;
    assign mem_be            = req_q.be;

    assign resp_ifetch = (state == ST_RESP) && (req_q.port == PORT_IFETCH);
    assign resp_data   = (state == ST_RESP) && (req_q.port == PORT_DATA);

    assign ifetch_rvalid = resp_ifetch;
    assign ifetch_rdata  = resp_ifetch ? rdata_q : '0;
    assign ifetch_err    = resp_ifetch && err_q;
    assign data_rvalid   = resp_data;
    assign data_rdata    = resp_data ? rdata_q : '0;
    assign data_err      = resp_data && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timing/response model.
module tb_mem_port_arbiter;

    localparam int          MEM_W   = 32;
    localparam logic [31:0] LIMIT   = 32'h0000_2000;
    localparam int          WR_LAT  = 2;
    localparam int          TIMEOUT = 1024;

    logic        clk;
    logic        rst;
    logic        prog_mode;
    logic        ifetch_req;
    logic [31:0] ifetch_addr;
    logic        ifetch_gnt;
    logic        ifetch_rvalid;
    logic [31:0] ifetch_rdata;
    logic        ifetch_err;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        memory_access;
    logic        memory_is_writing;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [3:0]  mem_be;
    logic [31:0] d_out;
    logic        out_valid;

    int n_total;
    int n_bad;
    bit m_last_data;

    mem_port_arbiter #(
        .MEM_W      (MEM_W),
        .SRAM_LIMIT (LIMIT),
        .WR_LAT     (WR_LAT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .prog_mode         (prog_mode),
        .ifetch_req        (ifetch_req),
        .ifetch_addr       (ifetch_addr),
        .ifetch_gnt        (ifetch_gnt),
        .ifetch_rvalid     (ifetch_rvalid),
        .ifetch_rdata      (ifetch_rdata),
        .ifetch_err        (ifetch_err),
        .data_req          (data_req),
        .data_we           (data_we),
        .data_be           (data_be),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_gnt          (data_gnt),
        .data_rvalid       (data_rvalid),
        .data_rdata        (data_rdata),
        .data_err          (data_err),
        .memory_access     (memory_access),
        .memory_is_writing (memory_is_writing),
        .addr              (addr),
        .d_in              (d_in),
        .mem_be            (mem_be),
        .d_out             (d_out),
        .out_valid         (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    // One transaction: request pattern, data-port fields, downstream read latency
    // (cycles from memory_access to out_valid; <1 means never respond) and read data.
    task automatic do_txn(input bit ri, input bit rd, input logic [31:0] ia, input logic [31:0] da,
                          input bit dwe, input logic [3:0] dbe, input logic [31:0] dwd,
                          input int lat, input logic [31:0] rsp);
        bit          win_d;
        bit          rej;
        bit          rd_op;
        bit          tmo;
        bit          eerr;
        int          ek;
        logic [31:0] ea;
        logic [31:0] erd;
        drive_pt();
        ifetch_req  = ri;
        data_req    = rd;
        ifetch_addr = ia;
        data_addr   = da;
        data_we     = dwe;
        data_be     = dbe;
        data_wdata  = dwd;
        prog_mode   = 1'b0;
        out_valid   = 1'b0;

        win_d       = (ri && rd) ? !m_last_data : rd;
        m_last_data = win_d;
        rd_op       = !(win_d && dwe);
        rej         = !rd_op && (da >= LIMIT);
        tmo         = rd_op && (lat < 1);
        if (rej)         ek = 2;
        else if (!rd_op) ek = 1 + 1 + WR_LAT + 1;
        else if (tmo)    ek = 1 + TIMEOUT + 1;
        else             ek = 1 + lat + 1;
        erd  = (rd_op && !tmo) ? rsp : 32'h0;
        eerr = rej || tmo;
        ea   = win_d ? da : ia;

        @(negedge clk);
        chk("grant", 96'({ifetch_gnt, data_gnt}), 96'({!win_d, win_d}));

        for (int k = 1; k <= ek; k++) begin
            drive_pt();
            ifetch_addr = $urandom;
            data_addr   = $urandom;
            data_wdata  = $urandom;
            data_be     = 4'($urandom);
            data_we     = 1'($urandom);
            prog_mode   = ($urandom_range(0, 3) == 0);
            d_out       = $urandom;
            out_valid   = 1'b0;
            if (rd_op && !tmo && (k == lat + 1)) begin
                out_valid = 1'b1;
                d_out     = rsp;
            end else if ((k == 1) || (k == ek) || !rd_op) begin
                out_valid = 1'($urandom);
            end
            @(negedge clk);
            chk("ctrl", 96'({ifetch_gnt, data_gnt, ifetch_rvalid, data_rvalid, memory_access}),
                96'({2'b00, (k == ek) && !win_d, (k == ek) && win_d, (k == 1) && !rej}));
            if (!rej) begin
                chk("held", 96'({addr, memory_is_writing, (!rd_op ? d_in : 32'h0), (!rd_op ? mem_be : 4'h0)}),
                    96'({ea, !rd_op, (!rd_op ? dwd : 32'h0), (!rd_op ? dbe : 4'h0)}));
            end
            if (k == ek) begin
                chk("rdata", 96'(win_d ? data_rdata : ifetch_rdata), 96'(erd));
                chk("err", 96'(win_d ? data_err : ifetch_err), 96'(eerr));
            end
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            drive_pt();
            if ($urandom_range(0, 1) == 1) begin
                prog_mode  = 1'b1;
                ifetch_req = 1'($urandom);
                data_req   = 1'($urandom);
            end else begin
                prog_mode  = 1'($urandom);
                ifetch_req = 1'b0;
                data_req   = 1'b0;
            end
            out_valid = 1'($urandom);
            d_out     = $urandom;
            @(negedge clk);
            chk("idle", 96'({ifetch_gnt, data_gnt, ifetch_rvalid, data_rvalid, memory_access}), 96'(0));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 96'({ifetch_gnt, data_gnt, ifetch_rvalid, data_rvalid, ifetch_err, data_err,
                                  memory_access, memory_is_writing}), 96'(0));
        chk({tag, "_bus"}, 96'({addr, mem_be, d_in}), 96'(0));
        chk({tag, "_rdata"}, 96'({ifetch_rdata, data_rdata}), 96'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total     = 0;
        n_bad       = 0;
        m_last_data = 1'b1;
        rst         = 1'b0;
        prog_mode   = 1'b0;
        ifetch_req  = 1'b0;
        ifetch_addr = 32'h0;
        data_req    = 1'b0;
        data_we     = 1'b0;
        data_be     = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        d_out       = 32'h0;
        out_valid   = 1'b0;

        #2;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Both ports requesting continuously: ifetch first, then strict alternation.
        for (int i = 0; i < 6; i++) begin
            do_txn(1'b1, 1'b1, 32'($urandom_range(0, 32'h1FFF)), 32'($urandom_range(0, 32'h1FFF)),
                   1'b0, 4'hF, 32'h0, int'($urandom_range(1, 3)), $urandom);
        end

        do_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 4'h0, 32'h0, 1, 32'hDEAD_BEEF);
        do_txn(1'b0, 1'b1, 32'h0, 32'h0000_0040, 1'b1, 4'b0011, 32'h1234_5678, 1, 32'h0);
        do_txn(1'b0, 1'b1, 32'h0, 32'h0000_4000, 1'b1, 4'hF, 32'hCAFE_F00D, 1, 32'h0);
        do_txn(1'b0, 1'b1, 32'h0, 32'h0000_1FFC, 1'b1, 4'b1000, 32'hA5A5_5A5A, 1, 32'h0);
        do_txn(1'b0, 1'b1, 32'h0, LIMIT, 1'b1, 4'hF, 32'h0BAD_0BAD, 1, 32'h0);
        do_txn(1'b0, 1'b1, 32'h0, 32'h0000_3000, 1'b0, 4'hF, 32'h0, 2, 32'h7777_1111);
        gap(3);

        do_txn(1'b1, 1'b0, 32'h0010_0000, 32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0);
        do_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 4'h0, 32'h0, 4, 32'h0F0F_0F0F);

        // Reset asserted while a read is stuck in WAIT.
        drive_pt();
        ifetch_req  = 1'b1;
        data_req    = 1'b0;
        ifetch_addr = 32'h0000_0300;
        prog_mode   = 1'b0;
        out_valid   = 1'b0;
        @(negedge clk);
        chk("rst_txn_gnt", 96'({ifetch_gnt, data_gnt}), 96'(2'b10));
        drive_pt();
        ifetch_req = 1'b0;
        drive_pt();
        drive_pt();
        #2 rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        m_last_data = 1'b1;
        drive_pt();
        drive_pt();
        rst = 1'b1;
        gap(4);
        do_txn(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 4'hF, 32'h0, 1, 32'h1357_9BDF);

        for (int t = 0; t < 200; t++) begin
            bit          ri;
            bit          rd;
            logic [31:0] da;
            ri = 1'($urandom);
            rd = 1'($urandom);
            if (!ri && !rd) rd = 1'b1;
            if ($urandom_range(0, 3) == 0) da = LIMIT + 32'($urandom_range(0, 32'hFFFF));
            else                           da = 32'($urandom_range(0, 32'h1FFF));
            do_txn(ri, rd, 32'($urandom_range(0, 32'h1FFF)), da, 1'($urandom), 4'($urandom),
                   $urandom, int'($urandom_range(1, 5)), $urandom);
            if ($urandom_range(0, 2) == 0) gap(int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
